// File: rtl/chart_pkg.sv
// chart_pkg: shared state encoding, note codes and note-to-lane decode for the chart player.
package chart_pkg;
    typedef enum logic [2:0] {IDLE, COUNT, PLAY, TAIL, PAUSE} state_t;
    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_L1 = 4'd1;
    localparam logic [3:0] NOTE_L2 = 4'd2;
    localparam logic [3:0] NOTE_L3 = 4'd3;
    localparam logic [3:0] NOTE_L4 = 4'd4;
    localparam logic [3:0] NOTE_L5 = 4'd5;
    // Lane 1 maps to the MSB of a LANES-wide key; out-of-range codes are rests.
    function automatic logic [15:0] note_key(input logic [3:0] code, input int lanes);
        return (code >= NOTE_L1 && int'(code) <= lanes) ? 16'(1) << (lanes - int'(code)) : '0;
    endfunction
endpackage

// File: rtl/chart_player_ctrl_if.sv
// chart_player_ctrl_if: control, chart ROM and lane-key signals of the chart player.
interface chart_player_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DIV_W = 24,
    parameter int LANES = 5
);
    logic start, pause, stop;
    logic [ADDR_W-1:0] song_len, rom_addr;
    logic [DIV_W-1:0] beat_div;
    logic [3:0] rom_note;
    logic [LANES-1:0] key;
    logic beat, busy, done;
    logic [2:0] countdown;
    modport master (
        output start, pause, stop, song_len, beat_div, rom_note,
        input rom_addr, key, beat, busy, done, countdown
    );
    modport slave (
        input start, pause, stop, song_len, beat_div, rom_note,
        output rom_addr, key, beat, busy, done, countdown
    );
endinterface

// File: rtl/beat_divider.sv
// beat_divider: counts clocks per beat and flags the last clock of each beat.
module beat_divider #(
    parameter int DIV_W = 24
) (
    input logic clk,
    input logic rst_n,
    input logic clr,
    input logic en,
    input logic [DIV_W-1:0] div,
    output logic tick
);
    logic [DIV_W-1:0] div_cnt, d;
    assign d = (div == '0) ? DIV_W'(1) : div;
    assign tick = en && div_cnt == d - 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else if (clr) div_cnt <= '0;
        else if (en) div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
endmodule

// File: rtl/chart_player_ctrl.sv
// chart_player_ctrl: beat-clocked chart ROM stepper with count-in, pause and lane-key decode.
module chart_player_ctrl
    import chart_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DIV_W = 24,
    parameter int LANES = 5,
    parameter int COUNT_BEATS = 4
) (
    input logic clk,
    input logic rst_n,
    chart_player_ctrl_if.slave bus
);
    state_t state, ret;
    logic [ADDR_W-1:0] len_q;
    logic [DIV_W-1:0] div_q;
    logic go, run, tick, last;
    assign go = bus.start && !bus.stop && state == IDLE;
    assign run = state inside {COUNT, PLAY, TAIL};
    assign last = bus.rom_addr == len_q;
    assign bus.beat = tick;
    beat_divider #(.DIV_W(DIV_W)) u_div (
        .clk(clk), .rst_n(rst_n), .clr(go || bus.stop), .en(run), .div(div_q), .tick(tick)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ret <= PLAY;
            len_q <= '0;
            div_q <= '0;
            bus.rom_addr <= '0;
            bus.key <= '0;
            bus.countdown <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.stop) begin
                state <= IDLE;
                bus.busy <= 1'b0;
                bus.rom_addr <= '0;
                bus.key <= '0;
                bus.countdown <= '0;
            end else begin
                case (state)
                    IDLE: if (go) begin
                        state <= COUNT;
                        bus.busy <= 1'b1;
                        bus.countdown <= 3'(COUNT_BEATS);
                        bus.rom_addr <= '0;
                        bus.key <= '0;
                        len_q <= bus.song_len;
                        div_q <= bus.beat_div;
                    end
                    COUNT: if (tick) begin
                        if (bus.countdown > 3'd1) bus.countdown <= bus.countdown - 3'd1;
                        else begin
                            bus.countdown <= '0;
                            bus.key <= LANES'(note_key(bus.rom_note, LANES));
                            state <= (len_q == '0) ? TAIL : PLAY;
                            bus.rom_addr <= (len_q == '0) ? '0 : ADDR_W'(1);
                        end
                    end
                    PLAY: if (tick) begin
                        bus.key <= LANES'(note_key(bus.rom_note, LANES));
                        if (last) state <= TAIL;
                        else bus.rom_addr <= bus.rom_addr + 1'b1;
                    end
                    TAIL: if (tick) begin
                        state <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.key <= '0;
                        bus.rom_addr <= '0;
                    end
                    PAUSE: if (bus.pause) state <= ret;
                    default: state <= IDLE;
                endcase
                // A pause on a beat edge still takes that beat; the return state reflects it.
                if (bus.pause && (state == PLAY || (state == TAIL && !tick))) begin
                    state <= PAUSE;
                    ret <= (state == PLAY && tick && last) ? TAIL : state;
                end
            end
        end
    end
endmodule

// File: tb/tb_chart_player_ctrl.sv
// tb_chart_player_ctrl: scoreboard bench; expected output-change events are queued, a monitor pops on each change.
module tb_chart_player_ctrl;
    import chart_pkg::*;
    typedef struct {int e; logic [17:0] v;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] rom [256];
    int ec = 0, t0 = 0, vecs = 0, miss = 0;
    bit mon_en = 1'b0;
    exp_t q[$];
    exp_t x;
    logic [17:0] cur, prev = '0;
    chart_player_ctrl_if bus ();
    chart_player_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) ec <= ec + 1;
    always_comb bus.rom_note = rom[bus.rom_addr];
    function automatic logic [17:0] tup();
        return {bus.key, bus.rom_addr, bus.countdown, bus.busy, bus.done};
    endfunction
    always @(negedge clk) if (mon_en) begin
        cur = tup();
        if (cur != prev) begin
            vecs++;
            if (q.size() == 0) begin
                miss++;
                $display("FAIL unexpected_event edge %0d got %h", ec - t0, cur);
            end else begin
                x = q.pop_front();
                if (ec - t0 != x.e || cur != x.v) begin
                    miss++;
                    $display("FAIL event edge/value got %0d/%h expected %0d/%h", ec - t0, cur, x.e, x.v);
                end
            end
            prev = cur;
        end
    end
    task automatic ex(input int e, input logic [4:0] k, input logic [7:0] a, input logic [2:0] c,
                      input logic b, input logic d);
        q.push_back('{e: e, v: {k, a, c, b, d}});
    endtask
    task automatic wait_edge(input int k);
        while (ec < t0 + k) @(negedge clk);
    endtask
    task automatic go(input logic [23:0] d, input logic [7:0] len);
        bus.beat_div = d;
        bus.song_len = len;
        bus.start = 1'b1;
        t0 = ec + 1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.song_len = 8'hFF;
        bus.beat_div = 24'd9;
    endtask
    task automatic drain(input int k, input string name);
        wait_edge(k);
        vecs++;
        if (q.size() != 0) begin
            miss++;
            $display("FAIL %s pending_events got %0d expected 0", name, q.size());
            q.delete();
        end
    endtask
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask
    task automatic push_count();
        ex(0, 5'b00000, 0, 4, 1, 0);
        ex(4, 5'b00000, 0, 3, 1, 0);
        ex(8, 5'b00000, 0, 2, 1, 0);
        ex(12, 5'b00000, 0, 1, 1, 0);
        ex(16, 5'b01000, 1, 0, 1, 0);
    endtask
    task automatic song1(input string name);
        push_count();
        ex(20, 5'b00000, 2, 0, 1, 0);
        ex(24, 5'b00001, 2, 0, 1, 0);
        ex(28, 5'b00000, 0, 0, 0, 1);
        ex(29, 5'b00000, 0, 0, 0, 0);
        go(24'd4, 8'd2);
        wait_edge(2);
        chk({name, "_beat_e2"}, 32'(bus.beat), 32'd0);
        wait_edge(3);
        chk({name, "_beat_e3"}, 32'(bus.beat), 32'd1);
        drain(34, name);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        int nb;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.stop = 1'b0;
        bus.song_len = '0;
        bus.beat_div = '0;
        foreach (rom[i]) rom[i] = NOTE_REST;
        rom[0] = NOTE_L2;
        rom[1] = NOTE_REST;
        rom[2] = NOTE_L5;
        rom[3] = NOTE_L4;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({tup(), bus.beat}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        song1("normal");
        push_count();
        ex(30, 5'b00000, 2, 0, 1, 0);
        ex(34, 5'b00001, 2, 0, 1, 0);
        ex(38, 5'b00000, 0, 0, 0, 1);
        ex(39, 5'b00000, 0, 0, 0, 0);
        go(24'd4, 8'd2);
        wait_edge(17);
        bus.pause = 1'b1;
        @(negedge clk);
        bus.pause = 1'b0;
        wait_edge(27);
        bus.pause = 1'b1;
        @(negedge clk);
        bus.pause = 1'b0;
        drain(44, "pause");
        push_count();
        ex(20, 5'b00000, 2, 0, 1, 0);
        ex(21, 5'b00000, 0, 0, 0, 0);
        go(24'd4, 8'd2);
        wait_edge(20);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        drain(30, "stop");
        song1("replay");
        rom[0] = NOTE_L3;
        ex(0, 5'b00000, 0, 4, 1, 0);
        ex(1, 5'b00000, 0, 3, 1, 0);
        ex(2, 5'b00000, 0, 2, 1, 0);
        ex(3, 5'b00000, 0, 1, 1, 0);
        ex(4, 5'b00100, 0, 0, 1, 0);
        ex(5, 5'b00000, 0, 0, 0, 1);
        ex(6, 5'b00000, 0, 0, 0, 0);
        go(24'd0, 8'd0);
        nb = 0;
        for (int k = 0; k < 5; k++) begin
            wait_edge(k);
            nb += int'(bus.beat);
        end
        chk("degen_beat_count", 32'(nb), 32'd5);
        wait_edge(5);
        chk("degen_beat_after", 32'(bus.beat), 32'd0);
        drain(10, "degen");
        rom[0] = NOTE_L2;
        push_count();
        ex(18, 5'b00000, 0, 0, 0, 0);
        go(24'd4, 8'd2);
        wait_edge(16);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop = 1'b1;
        bus.pause = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        bus.pause = 1'b0;
        drain(22, "stop_pause");
        push_count();
        ex(20, 5'b00000, 2, 0, 1, 0);
        ex(24, 5'b00001, 2, 0, 1, 0);
        ex(25, 5'b00000, 0, 0, 0, 0);
        go(24'd4, 8'd2);
        wait_edge(5);
        bus.pause = 1'b1;
        @(negedge clk);
        bus.pause = 1'b0;
        wait_edge(24);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'({tup(), bus.beat}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain(35, "reset_tail");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
